// File: rtl/l2_buffer_pkg.sv
// l2_buffer_pkg
//   Shared constants and helpers for the L2 line assembly buffer.
//   - clog2 / max1 helpers used to size ports and pointers.
//   - Default configuration and the constants derived from it (RATIO,
//     BEAT_IDX_W, COUNT_W).
//   - cfg_ok(): legality check of a configuration. It is evaluated for the
//     defaults here and for the actual parameters inside the top level.
package l2_buffer_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int calc_ratio(input int buffer_width, input int bus_width);
        return buffer_width / bus_width;
    endfunction

    // A RATIO=1 build still gets a one-bit beat index so the port exists.
    function automatic int calc_beat_idx_w(input int ratio);
        return max1(clog2(ratio));
    endfunction

    function automatic int calc_count_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit cfg_ok(input int buffer_width, input int bus_width, input int depth);
        return (bus_width > 0) && (buffer_width >= bus_width) &&
               (buffer_width % bus_width == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam int DEF_L2_BUS_WIDTH = 64;
    localparam int DEF_BUFFER_WIDTH = 128;
    localparam int DEF_DEPTH        = 4;

    localparam int RATIO      = calc_ratio(DEF_BUFFER_WIDTH, DEF_L2_BUS_WIDTH);
    localparam int BEAT_IDX_W = calc_beat_idx_w(RATIO);
    localparam int COUNT_W    = calc_count_w(DEF_DEPTH);
    localparam bit DEF_CFG_OK = cfg_ok(DEF_BUFFER_WIDTH, DEF_L2_BUS_WIDTH, DEF_DEPTH);

endpackage

// File: rtl/l2_line_fifo.sv
// l2_line_fifo
//   DEPTH-entry FIFO of assembled lines (DEPTH a power of two).
//   Ports:
//     clk, rst_n  clock / asynchronous active-low reset
//     flush       synchronous clear of pointers and count (storage kept)
//     push, wdata write one line at the write pointer
//     pop         advance the read pointer
//     rdata       line at the read pointer (asynchronous read)
//     count       lines held, 0..DEPTH
//     full, empty occupancy flags
module l2_line_fifo
    import l2_buffer_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata,
    output logic [calc_count_w(DEPTH)-1:0]  count,
    output logic                            full,
    output logic                            empty
);
    localparam int PTR_W = max1(clog2(DEPTH));
    localparam int CNT_W = calc_count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; rdata is only meaningful while !empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_line_assembly_buffer.sv
// l2_line_assembly_buffer
//   Packs RATIO = BUFFER_WIDTH/L2_BUS_WIDTH L2 beats (low slice first) into
//   one line and queues complete lines in a DEPTH-entry FIFO.
//   Ports:
//     CLK, RSTN                  clock / asynchronous active-low reset
//     ENB                        global enable; low freezes all state
//     FLUSH                      discard partial line and queued lines
//     DATA_FROM_L2[_VALID/READY] beat input handshake
//     DATA_FROM_L2_BUFFER[_VALID/READY] line output handshake (FIFO head)
//     BUFFER_COUNT               complete lines queued
//     BEAT_INDEX                 index of the next beat expected
module l2_line_assembly_buffer
    import l2_buffer_pkg::*;
#(
    parameter int L2_BUS_WIDTH = DEF_L2_BUS_WIDTH,
    parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int DEPTH        = DEF_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     ENB,
    input  logic                     FLUSH,
    input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2,
    input  logic                     DATA_FROM_L2_VALID,
    output logic                     DATA_FROM_L2_READY,
    output logic [BUFFER_WIDTH-1:0]  DATA_FROM_L2_BUFFER,
    output logic                     DATA_FROM_L2_BUFFER_VALID,
    input  logic                     DATA_FROM_L2_BUFFER_READY,
    output logic [calc_count_w(DEPTH)-1:0] BUFFER_COUNT,
    output logic [calc_beat_idx_w(calc_ratio(BUFFER_WIDTH, L2_BUS_WIDTH))-1:0] BEAT_INDEX
);
    localparam int LINE_RATIO = calc_ratio(BUFFER_WIDTH, L2_BUS_WIDTH);
    localparam int IDX_W      = calc_beat_idx_w(LINE_RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_RATIO - 1);

    generate
        if (!cfg_ok(BUFFER_WIDTH, L2_BUS_WIDTH, DEPTH)) begin : g_bad_cfg
            $error("l2_line_assembly_buffer: BUFFER_WIDTH must be a multiple of L2_BUS_WIDTH and DEPTH a power of 2 >= 2");
        end
    endgenerate

    logic [IDX_W-1:0]        beat_idx;
    logic                    last_beat, ready, accept, push, pop;
    logic                    fifo_full, fifo_empty;
    logic [BUFFER_WIDTH-1:0] line;

    // Readiness never looks at the consumer side: a full FIFO blocks the
    // final beat even when a pop happens in the same cycle.
    assign last_beat = (beat_idx == LAST_IDX);
    assign ready     = ENB & ~FLUSH & (~last_beat | ~fifo_full);
    assign accept    = DATA_FROM_L2_VALID & ready;
    assign push      = accept & last_beat;
    assign pop       = ~fifo_empty & DATA_FROM_L2_BUFFER_READY & ENB & ~FLUSH;

    // FLUSH wins over ENB; accept already implies ENB.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            beat_idx <= '0;
        end else if (FLUSH) begin
            beat_idx <= '0;
        end else if (accept) begin
            beat_idx <= last_beat ? '0 : beat_idx + IDX_W'(1);
        end
    end

    generate
        if (LINE_RATIO == 1) begin : g_direct
            assign line = DATA_FROM_L2;
        end else begin : g_asm
            localparam int LOW_W = BUFFER_WIDTH - L2_BUS_WIDTH;
            logic [LOW_W-1:0] asm_q;

            // Only the lower RATIO-1 slices are registered; the final beat
            // goes straight into the FIFO write data.
            always_ff @(posedge CLK) begin
                if (accept && !last_beat) begin
                    for (int k = 0; k < LINE_RATIO - 1; k++) begin
                        if (beat_idx == IDX_W'(k))
                            asm_q[k*L2_BUS_WIDTH +: L2_BUS_WIDTH] <= DATA_FROM_L2;
                    end
                end
            end

            assign line = {DATA_FROM_L2, asm_q};
        end
    endgenerate

    l2_line_fifo #(
        .WIDTH (BUFFER_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .flush (FLUSH),
        .push  (push),
        .pop   (pop),
        .wdata (line),
        .rdata (DATA_FROM_L2_BUFFER),
        .count (BUFFER_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign DATA_FROM_L2_READY        = ready;
    assign DATA_FROM_L2_BUFFER_VALID = ~fifo_empty;
    assign BEAT_INDEX                = beat_idx;

endmodule

// File: tb/tb_l2_line_assembly_buffer.sv
// Bench for l2_line_assembly_buffer: a default build (64->128, depth 4) and a
// RATIO=1 build (64->64, consumer always ready) share the same input stream.
// A queue-based model checks both on every falling edge; directed sequences
// pin the model with literal expectations.
module tb_l2_line_assembly_buffer;
    localparam int LW    = 64;
    localparam int BW    = 128;
    localparam int DEPTH = 4;
    localparam int RATIO = BW / LW;

    logic          CLK, RSTN, ENB, FLUSH;
    logic [LW-1:0] DATA;
    logic          DVALID, BR;

    logic          rdy, bvalid;
    logic [BW-1:0] buf_d;
    logic [2:0]    cnt;
    logic [0:0]    bidx;

    logic          rdy1, bvalid1;
    logic [LW-1:0] buf1;
    logic [2:0]    cnt1;
    logic [0:0]    bidx1;

    int tests = 0;
    int fails = 0;

    l2_line_assembly_buffer #(.L2_BUS_WIDTH(LW), .BUFFER_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .ENB(ENB), .FLUSH(FLUSH),
        .DATA_FROM_L2(DATA), .DATA_FROM_L2_VALID(DVALID), .DATA_FROM_L2_READY(rdy),
        .DATA_FROM_L2_BUFFER(buf_d), .DATA_FROM_L2_BUFFER_VALID(bvalid),
        .DATA_FROM_L2_BUFFER_READY(BR), .BUFFER_COUNT(cnt), .BEAT_INDEX(bidx)
    );

    l2_line_assembly_buffer #(.L2_BUS_WIDTH(LW), .BUFFER_WIDTH(LW), .DEPTH(DEPTH)) dut_r1 (
        .CLK(CLK), .RSTN(RSTN), .ENB(ENB), .FLUSH(FLUSH),
        .DATA_FROM_L2(DATA), .DATA_FROM_L2_VALID(DVALID), .DATA_FROM_L2_READY(rdy1),
        .DATA_FROM_L2_BUFFER(buf1), .DATA_FROM_L2_BUFFER_VALID(bvalid1),
        .DATA_FROM_L2_BUFFER_READY(1'b1), .BUFFER_COUNT(cnt1), .BEAT_INDEX(bidx1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: beats of the partial line, queued lines, and the
    // RATIO=1 build's queue.
    logic [LW-1:0] part[$];
    logic [BW-1:0] q[$];
    logic [LW-1:0] q1[$];

    always @(negedge CLK) begin
        logic          e_rdy, e_rdy1, acc, acc1, pp, pp1;
        logic [BW-1:0] ln;
        if (!RSTN) begin
            part.delete(); q.delete(); q1.delete();
        end
        e_rdy  = ENB && !FLUSH && (part.size() != RATIO - 1 || q.size() != DEPTH);
        e_rdy1 = ENB && !FLUSH && (q1.size() != DEPTH);
        chk("ready", BW'(rdy), BW'(e_rdy));
        chk("valid", BW'(bvalid), BW'(q.size() > 0));
        chk("count", BW'(cnt), BW'(q.size()));
        chk("beat_index", BW'(bidx), BW'(part.size()));
        if (q.size() > 0) chk("line", buf_d, q[0]);
        chk("r1_ready", BW'(rdy1), BW'(e_rdy1));
        chk("r1_valid", BW'(bvalid1), BW'(q1.size() > 0));
        chk("r1_count", BW'(cnt1), BW'(q1.size()));
        chk("r1_beat_index", BW'(bidx1), '0);
        if (q1.size() > 0) chk("r1_line", BW'(buf1), BW'(q1[0]));
        if (RSTN) begin
            acc  = DVALID && e_rdy;
            acc1 = DVALID && e_rdy1;
            pp   = (q.size() > 0) && BR && ENB && !FLUSH;
            pp1  = (q1.size() > 0) && ENB && !FLUSH;
            if (FLUSH) begin
                part.delete(); q.delete(); q1.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) begin
                    part.push_back(DATA);
                    if (part.size() == RATIO) begin
                        ln = '0;
                        foreach (part[k]) ln[k*LW +: LW] = part[k];
                        q.push_back(ln);
                        part.delete();
                    end
                end
                if (pp1) void'(q1.pop_front());
                if (acc1) q1.push_back(DATA);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_line(input logic [LW-1:0] lo, input logic [LW-1:0] hi);
        DVALID = 1'b1; DATA = lo; step();
        DATA = hi; step();
        DVALID = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int maxc;
        RSTN = 1'b1; ENB = 1'b0; FLUSH = 1'b0; DVALID = 1'b0; BR = 1'b0; DATA = '0;
        #1 RSTN = 1'b0;
        repeat (3) step();
        RSTN = 1'b1;
        #1;
        chk("rst_valid", BW'(bvalid), '0);
        chk("rst_count", BW'(cnt), '0);
        chk("rst_beat", BW'(bidx), '0);
        chk("rst_ready_enb0", BW'(rdy), '0);
        ENB = 1'b1; #1;
        chk("rst_ready_enb1", BW'(rdy), BW'(1));
        step();

        // First line: two beats, visible the cycle after the second accept.
        DVALID = 1'b1; DATA = {16{4'h1}};
        step();
        chk("t1_beat_after_b0", BW'(bidx), BW'(1));
        chk("t1_valid_early", BW'(bvalid), '0);
        chk("r1_one_cycle_valid", BW'(bvalid1), BW'(1));
        chk("r1_one_cycle_data", BW'(buf1), BW'({16{4'h1}}));
        DATA = {16{4'h2}};
        step();
        DVALID = 1'b0;
        chk("t1_valid", BW'(bvalid), BW'(1));
        chk("t1_line", buf_d, {{16{4'h2}}, {16{4'h1}}});
        chk("t1_count", BW'(cnt), BW'(1));
        chk("r1_second_beat", BW'(buf1), BW'({16{4'h2}}));

        // Fill to DEPTH, then only the final beat of a line stalls.
        repeat (3) send_line(rnd64(), rnd64());
        chk("full_count", BW'(cnt), BW'(4));
        DVALID = 1'b1; DATA = rnd64(); #1;
        chk("full_first_beat_ready", BW'(rdy), BW'(1));
        step();
        chk("full_beat_idx", BW'(bidx), BW'(1));
        chk("full_count_hold", BW'(cnt), BW'(4));
        DATA = rnd64(); #1;
        chk("full_last_beat_stall", BW'(rdy), '0);
        step();
        chk("full_stall_beat", BW'(bidx), BW'(1));
        BR = 1'b1; #1;
        chk("pop_no_bypass", BW'(rdy), '0);
        step();
        BR = 1'b0; #1;
        chk("after_pop_count", BW'(cnt), BW'(3));
        chk("after_pop_ready", BW'(rdy), BW'(1));
        step();
        DVALID = 1'b0;
        chk("refill_count", BW'(cnt), BW'(4));
        chk("refill_beat", BW'(bidx), '0);
        BR = 1'b1;
        repeat (5) step();
        BR = 1'b0;
        chk("drained", BW'(cnt), '0);

        // Continuous stream of 10 lines with the consumer always ready.
        BR = 1'b1; DVALID = 1'b1; maxc = 0;
        repeat (2 * 10) begin
            DATA = rnd64();
            step();
            if (int'(cnt) > maxc) maxc = int'(cnt);
        end
        DVALID = 1'b0;
        step(); step();
        chk("stream_max_count", BW'(maxc <= 2), BW'(1));
        chk("stream_drained", BW'(cnt), '0);
        BR = 1'b0;

        // ENB low mid-line: nothing moves, no pop.
        send_line(rnd64(), rnd64());
        DVALID = 1'b1; DATA = rnd64(); step();
        ENB = 1'b0; BR = 1'b1; DATA = rnd64();
        repeat (3) begin
            #1 chk("enb0_ready", BW'(rdy), '0);
            step();
            chk("enb0_beat", BW'(bidx), BW'(1));
            chk("enb0_count", BW'(cnt), BW'(1));
        end
        ENB = 1'b1; BR = 1'b0;
        step();
        DVALID = 1'b0;
        chk("enb_resume_count", BW'(cnt), BW'(2));
        chk("enb_resume_beat", BW'(bidx), '0);

        // FLUSH with a partial line and three queued lines.
        FLUSH = 1'b1; step(); FLUSH = 1'b0;
        chk("flush0_count", BW'(cnt), '0);
        repeat (3) send_line(rnd64(), rnd64());
        DVALID = 1'b1; DATA = rnd64(); step();
        chk("preflush_count", BW'(cnt), BW'(3));
        chk("preflush_beat", BW'(bidx), BW'(1));
        FLUSH = 1'b1; BR = 1'b1; #1;
        chk("flush_ready", BW'(rdy), '0);
        step();
        FLUSH = 1'b0; BR = 1'b0; DVALID = 1'b0;
        chk("flush_count", BW'(cnt), '0);
        chk("flush_valid", BW'(bvalid), '0);
        chk("flush_beat", BW'(bidx), '0);
        send_line({16{4'hA}}, {16{4'hB}});
        chk("postflush_line", buf_d, {{16{4'hB}}, {16{4'hA}}});
        chk("postflush_count", BW'(cnt), BW'(1));
        ENB = 1'b0; FLUSH = 1'b1; step();
        FLUSH = 1'b0; ENB = 1'b1;
        chk("flush_enb0_count", BW'(cnt), '0);

        // Randomised traffic, first with a slow consumer then a fast one.
        for (int i = 0; i < 3000; i++) begin
            ENB    = ($urandom_range(0, 9) != 0);
            FLUSH  = ($urandom_range(0, 59) == 0);
            DVALID = ($urandom_range(0, 3) != 0);
            BR     = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            DATA   = rnd64();
            step();
        end
        ENB = 1'b1; FLUSH = 1'b0; DVALID = 1'b0; BR = 1'b0;
        FLUSH = 1'b1; step(); FLUSH = 1'b0;

        // Asynchronous reset mid-line with two lines queued.
        send_line(rnd64(), rnd64());
        send_line(rnd64(), rnd64());
        DVALID = 1'b1; DATA = rnd64(); step();
        DVALID = 1'b0;
        chk("prerst_count", BW'(cnt), BW'(2));
        RSTN = 1'b0; #1;
        chk("async_rst_valid", BW'(bvalid), '0);
        chk("async_rst_count", BW'(cnt), '0);
        chk("async_rst_beat", BW'(bidx), '0);
        step();
        RSTN = 1'b1;
        send_line({16{4'hC}}, {16{4'hD}});
        chk("postrst_line", buf_d, {{16{4'hD}}, {16{4'hC}}});
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
